fifo_dma: RTL and testbench

- Background sequencer that drains the arm-to-moto byte FIFO (the 2048-deep byte FIFO fed by the PI side) into a shared 16-bit memory.
- Pops bytes from the FIFO's edge-synchronised read port.
- Writes each byte to a byte address through a request/acknowledge port on a memory arbitrated with the CPU.
- Counts progress and signals completion; lets the MCU preload RAM/ROM areas without CPU involvement.

---
 rtl/fifo_dma_pkg.sv | 34 +++
 rtl/fifo_dma_wr.sv | 68 ++++++
 rtl/fifo_dma.sv | 167 ++++++++++++++++
 tb/tb_fifo_dma.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_dma_pkg.sv
// Shared definitions for the FIFO-to-memory byte sequencer.
//   - FSM state encodings
//   - default FIFO read-settle latency
//   - memory write beat payload and its byte-lane builder
package fifo_dma_pkg;

  localparam int unsigned FIFO_LAT_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_POP   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // One 16-bit memory write: data plus per-lane byte enables.
  typedef struct packed {
    logic        we_hi;
    logic        we_lo;
    logic [15:0] di;
  } mem_beat_t;

  // Even byte addresses live in the high lane, odd in the low lane;
  // the byte is replicated so either lane sees it.
  function automatic mem_beat_t lane_beat(input logic [7:0] b, input logic odd);
    mem_beat_t beat;
    beat.we_hi = ~odd;
    beat.we_lo = odd;
    beat.di    = {b, b};
    return beat;
  endfunction

endpackage

// File: rtl/fifo_dma_wr.sv
// Byte-lane write port holder.
// Captures address/data/byte-enables when a write is launched and holds
// them, together with mem_req, until the arbiter acknowledges.
//   clk, rst          : clock (falling edge active), sync active-high reset
//   load              : launch a write with ptr/data
//   flush             : drop an outstanding request (abort)
//   ack               : arbiter grant, write completes this cycle
//   ptr, data         : byte address and byte to write
//   mem_req .. we_lo  : registered memory port
module fifo_dma_wr
  import fifo_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic              ack,
  input  logic [ADDR_W-1:0] ptr,
  input  logic [7:0]        data,
  output logic              mem_req,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_di,
  output logic              mem_we_hi,
  output logic              mem_we_lo
);

  logic              req_q,  req_d;
  logic [ADDR_W-2:0] addr_q, addr_d;
  mem_beat_t         beat_q, beat_d;

  // Launch / hold / release of the request and its payload.
  always_comb begin
    req_d  = req_q;
    addr_d = addr_q;
    beat_d = beat_q;
    if (load) begin
      req_d  = 1'b1;
      addr_d = ptr[ADDR_W-1:1];
      beat_d = lane_beat(data, ptr[0]);
    end else if (flush || (req_q && ack)) begin
      // Address and data stay put; only the strobes are released.
      req_d        = 1'b0;
      beat_d.we_hi = 1'b0;
      beat_d.we_lo = 1'b0;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      beat_q <= '0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
      beat_q <= beat_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_di    = beat_q.di;
  assign mem_we_hi = beat_q.we_hi;
  assign mem_we_lo = beat_q.we_lo;

endmodule

// File: rtl/fifo_dma.sv
// Background sequencer draining the byte FIFO into 16-bit shared memory.
// Registers update on the falling clock edge to line up with the FIFO.
//   clk, rst             : clock, synchronous active-high reset
//   start, abort         : transfer control
//   dst_addr, len        : byte start address and byte count (sampled on start)
//   busy, done, xfer_cnt : status
//   fifo_empty, fifo_do  : FIFO head flag/data
//   fifo_oe              : FIFO pop pulse
//   mem_*                : request/ack byte write port
module fifo_dma
  import fifo_dma_pkg::*;
#(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned LEN_W    = 12,
  parameter int unsigned FIFO_LAT = FIFO_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  xfer_cnt,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_do,
  output logic              fifo_oe,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_di,
  output logic              mem_we_hi,
  output logic              mem_we_lo
);

  localparam int unsigned SET_W = (FIFO_LAT < 1) ? 1 : $clog2(FIFO_LAT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [LEN_W-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic [7:0]        data_q, data_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fifo_oe_q, fifo_oe_d;

  logic              accept_c;
  logic              wr_ack_c;
  logic              wr_load_c;
  logic              wr_flush_c;

  // A start is taken only from IDLE, and a coincident abort suppresses it.
  assign accept_c = (state_q == ST_IDLE) && start && !abort;
  // Write completes in the ack cycle even if abort arrives alongside it.
  assign wr_ack_c = (state_q == ST_WRITE) && mem_ack;

  // State register.
  always_ff @(negedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort overrides every active state.
  always_comb begin
    state_d = state_q;
    if ((state_q != ST_IDLE) && abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (accept_c) state_d = (len == '0) ? ST_DONE : ST_WAIT;
        ST_WAIT:  if (!fifo_empty && (settle_q == '0)) state_d = ST_POP;
        ST_POP:   state_d = ST_WRITE;
        ST_WRITE: if (mem_ack) state_d = (remain_q == LEN_W'(1)) ? ST_DONE : ST_WAIT;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    busy_d     = 1'b0;
    done_d     = 1'b0;
    fifo_oe_d  = 1'b0;
    wr_load_c  = 1'b0;
    wr_flush_c = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    fifo_oe_d  = (state_d == ST_POP);
    wr_load_c  = (state_q == ST_POP) && (state_d == ST_WRITE);
    wr_flush_c = abort;
  end

  // Pointer, length, progress count, data latch and settle timer.
  always_comb begin
    ptr_d      = ptr_q;
    remain_d   = remain_q;
    xfer_cnt_d = xfer_cnt_q;
    data_d     = data_q;
    settle_d   = (settle_q != '0) ? settle_q - SET_W'(1) : settle_q;

    if (accept_c) begin
      ptr_d      = dst_addr;
      remain_d   = len;
      xfer_cnt_d = '0;
    end

    if ((state_q == ST_WAIT) && (state_d == ST_POP)) data_d = fifo_do;

    // The pop has already happened, so the FIFO needs its settle time
    // even if this cycle is aborted.
    if (state_q == ST_POP) settle_d = SET_W'(FIFO_LAT);

    if (wr_ack_c) begin
      ptr_d      = ptr_q + ADDR_W'(1);
      remain_d   = remain_q - LEN_W'(1);
      xfer_cnt_d = xfer_cnt_q + LEN_W'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      remain_q   <= '0;
      xfer_cnt_q <= '0;
      data_q     <= '0;
      settle_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fifo_oe_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      remain_q   <= remain_d;
      xfer_cnt_q <= xfer_cnt_d;
      data_q     <= data_d;
      settle_q   <= settle_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fifo_oe_q  <= fifo_oe_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign xfer_cnt = xfer_cnt_q;
  assign fifo_oe  = fifo_oe_q;

  fifo_dma_wr #(
    .ADDR_W (ADDR_W)
  ) u_wr (
    .clk       (clk),
    .rst       (rst),
    .load      (wr_load_c),
    .flush     (wr_flush_c),
    .ack       (mem_ack),
    .ptr       (ptr_q),
    .data      (data_q),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_di    (mem_di),
    .mem_we_hi (mem_we_hi),
    .mem_we_lo (mem_we_lo)
  );

endmodule

// File: tb/tb_fifo_dma.sv
// Randomized self-checking bench for fifo_dma with a behavioural FIFO and
// memory-port model. Inputs change on the rising edge; the DUT acts on the
// falling edge; the monitor snapshots #1 after the rising edge.
module tb_fifo_dma;

  localparam int unsigned ADDR_W   = 17;
  localparam int unsigned LEN_W    = 12;
  localparam int unsigned FIFO_LAT = 4;

  typedef struct packed {
    logic [ADDR_W-2:0] addr;
    logic              hi;
    logic              lo;
    logic [15:0]       di;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  xfer_cnt;
  logic              fifo_empty;
  logic [7:0]        fifo_do;
  logic              fifo_oe;
  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-2:0] mem_addr;
  logic [15:0]       mem_di;
  logic              mem_we_hi;
  logic              mem_we_lo;

  fifo_dma #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .FIFO_LAT (FIFO_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .xfer_cnt   (xfer_cnt),
    .fifo_empty (fifo_empty),
    .fifo_do    (fifo_do),
    .fifo_oe    (fifo_oe),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_addr   (mem_addr),
    .mem_di     (mem_di),
    .mem_we_hi  (mem_we_hi),
    .mem_we_lo  (mem_we_lo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fq[$];
  exp_t       exp_q[$];

  int ack_mode   = 0;   // 0: always ack, 1: random, 2: stall count
  int stall_left = 0;
  int lat_cnt    = 0;
  int cyc        = 0;
  int last_pop   = -1;
  int pops       = 0;
  int req_cycles = 0;
  int stalls     = 0;
  int holds      = 0;
  int done_cnt   = 0;

  int done_base, pop_base, req_base, stall_base, hold_base;

  logic              p_req, p_ack, p_we_hi, p_we_lo;
  logic [ADDR_W-2:0] p_addr;
  logic [15:0]       p_di;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // FIFO and arbiter model plus monitor.
  always @(posedge clk) begin
    if (lat_cnt > 0) begin
      lat_cnt--;
    end else begin
      fifo_empty = (fq.size() == 0);
      fifo_do    = (fq.size() == 0) ? 8'h00 : fq[0];
    end
    case (ack_mode)
      0:       mem_ack = 1'b1;
      1:       mem_ack = 1'($urandom_range(0, 1));
      default: mem_ack = !(mem_req && (stall_left > 0));
    endcase

    #1;
    cyc++;
    if (rst) begin
      last_pop = -1;
      lat_cnt  = 0;
      p_req    = 1'b0;
      p_ack    = 1'b0;
    end else begin
      if (fifo_oe) begin
        check("pop_nonempty", 64'(fq.size() != 0), 64'd1);
        if (fq.size() != 0) void'(fq.pop_front());
        pops++;
        if (last_pop >= 0)
          check("pop_gap", 64'((cyc - last_pop) >= int'(FIFO_LAT + 1)), 64'd1);
        last_pop = cyc;
        lat_cnt  = FIFO_LAT;
      end
      if (mem_req) req_cycles++;
      if (mem_req && !mem_ack) stalls++;
      if (ack_mode == 2 && mem_req && !mem_ack && stall_left > 0) stall_left--;
      if (p_req && !p_ack && mem_req) begin
        holds++;
        check("wr_hold", {30'd0, mem_addr, mem_di, mem_we_hi, mem_we_lo},
                         {30'd0, p_addr, p_di, p_we_hi, p_we_lo});
      end
      if (mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(e.addr));
          check("wr_di", 64'(mem_di), 64'(e.di));
          check("wr_lane", {62'd0, mem_we_hi, mem_we_lo}, {62'd0, e.hi, e.lo});
        end
      end
      if (done) done_cnt++;
      p_req   = mem_req;
      p_ack   = mem_ack;
      p_addr  = mem_addr;
      p_di    = mem_di;
      p_we_hi = mem_we_hi;
      p_we_lo = mem_we_lo;
    end
  end

  task automatic queue_byte(input logic [ADDR_W-1:0] a, input logic [7:0] b);
    exp_t e;
    fq.push_back(b);
    e.addr = a[ADDR_W-1:1];
    e.hi   = ~a[0];
    e.lo   = a[0];
    e.di   = {b, b};
    exp_q.push_back(e);
  endtask

  task automatic start_xfer(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n);
    @(posedge clk);
    done_base  = done_cnt;
    pop_base   = pops;
    req_base   = req_cycles;
    stall_base = stalls;
    hold_base  = holds;
    dst_addr   = a;
    len        = n;
    start      = 1'b1;
    @(posedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("done_seen", 64'(done_cnt - done_base), 64'd1);
  endtask

  task automatic finish_xfer(input string tag, input int want_cnt, input int want_pops);
    @(posedge clk);
    #2;
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    check({tag, "_done_low"}, 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    check({tag, "_done_once"}, 64'(done_cnt - done_base), 64'd1);
    check({tag, "_xfer_cnt"}, 64'(xfer_cnt), 64'(want_cnt));
    check({tag, "_pops"}, 64'(pops - pop_base), 64'(want_pops));
    check({tag, "_all_written"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_xfer_cnt"}, 64'(xfer_cnt), 64'd0);
    check({tag, "_fifo_oe"}, 64'(fifo_oe), 64'd0);
    check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, "_we"}, {62'd0, mem_we_hi, mem_we_lo}, 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_di"}, 64'(mem_di), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    dst_addr   = '0;
    len        = '0;
    fifo_empty = 1'b1;
    fifo_do    = 8'h00;
    mem_ack    = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    rst = 1'b0;

    // Normal three-byte transfer with immediate ack.
    ack_mode = 0;
    queue_byte(17'h00101, 8'h11);
    queue_byte(17'h00102, 8'h22);
    queue_byte(17'h00103, 8'h33);
    start_xfer(17'h00101, 12'd3);
    wait_done(200);
    finish_xfer("normal", 3, 3);

    // Zero length: immediate completion, no FIFO or memory traffic.
    start_xfer(17'h00055, 12'd0);
    wait_done(5);
    finish_xfer("zero", 0, 0);
    check("zero_no_req", 64'(req_cycles - req_base), 64'd0);

    // Ack stall on the first write of a two-byte transfer.
    ack_mode   = 2;
    stall_left = 7;
    queue_byte(17'h00200, 8'hA5);
    queue_byte(17'h00201, 8'h5A);
    start_xfer(17'h00200, 12'd2);
    wait_done(200);
    finish_xfer("stall", 2, 2);
    check("stall_cycles", 64'(stalls - stall_base), 64'd7);
    check("stall_holds", 64'(holds - hold_base), 64'd7);
    ack_mode = 0;

    // Empty FIFO parks the block; abort ends it without done.
    queue_byte(17'h00300, 8'hC3);
    queue_byte(17'h00301, 8'h3C);
    start_xfer(17'h00300, 12'd4);
    repeat (60) @(posedge clk);
    #2;
    check("park_busy", 64'(busy), 64'd1);
    check("park_xfer_cnt", 64'(xfer_cnt), 64'd2);
    check("park_written", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    abort = 1'b1;
    @(posedge clk);
    abort = 1'b0;
    #2;
    check("abort_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    check("abort_no_done", 64'(done_cnt - done_base), 64'd0);
    check("abort_xfer_cnt", 64'(xfer_cnt), 64'd2);

    // Address wrap, with a second start mid-transfer that must be ignored.
    queue_byte(17'h1FFFF, 8'h77);
    queue_byte(17'h00000, 8'h88);
    start_xfer(17'h1FFFF, 12'd2);
    repeat (3) @(posedge clk);
    dst_addr = 17'h00010;
    len      = 12'd5;
    start    = 1'b1;
    @(posedge clk);
    start    = 1'b0;
    wait_done(200);
    finish_xfer("wrap", 2, 2);

    // Reset while a write is pending.
    ack_mode   = 2;
    stall_left = 1000;
    queue_byte(17'h00040, 8'hEE);
    start_xfer(17'h00040, 12'd1);
    begin
      int n = 0;
      while (!mem_req && n < 40) begin
        @(posedge clk);
        #2;
        n++;
      end
    end
    check("rst_req_seen", 64'(mem_req), 64'd1);
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check_reset_outputs("midrst");
    @(posedge clk);
    rst        = 1'b0;
    stall_left = 0;
    ack_mode   = 0;
    exp_q.delete();
    queue_byte(17'h00041, 8'h4B);
    start_xfer(17'h00041, 12'd1);
    wait_done(200);
    finish_xfer("post_rst", 1, 1);

    // Start and abort together in IDLE: nothing starts.
    @(posedge clk);
    req_base  = req_cycles;
    pop_base  = pops;
    done_base = done_cnt;
    dst_addr  = 17'h00123;
    len       = 12'd3;
    start     = 1'b1;
    abort     = 1'b1;
    @(posedge clk);
    start     = 1'b0;
    abort     = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("startabort_busy", 64'(busy), 64'd0);
    check("startabort_no_req", 64'(req_cycles - req_base), 64'd0);
    check("startabort_no_done", 64'(done_cnt - done_base), 64'd0);

    // Randomized transfers against random arbitration.
    ack_mode = 1;
    for (int t = 0; t < 8; t++) begin
      logic [ADDR_W-1:0] a;
      int                n;
      a = ADDR_W'($urandom);
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) queue_byte(ADDR_W'(a + ADDR_W'(i)), 8'($urandom));
      start_xfer(a, LEN_W'(n));
      wait_done(400);
      finish_xfer("rand", n, n);
    end
    ack_mode = 0;

    check("fifo_drained", 64'(fq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
